// File: rtl/bit_balancer.sv
// rtl/bit_balancer.sv - registered population count of an input word
// Counts the '1' bits of `in` and presents the total one clock later.
module bit_balancer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] w_popcount;
  logic [CNT_W-1:0] r_count;

  // CNT_W holds WIDTH, so the running sum can never wrap.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcount = w_popcount + CNT_W'(in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_popcount;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_bit_balancer.sv
// tb/tb_bit_balancer.sv - directed bench for bit_balancer
// Each step drives a word, then checks the old count holds and the new one appears.
module tb_bit_balancer;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic [3:0] count;

  int checks;
  int passes;

  bit_balancer #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] expected);
    checks++;
    assert (count === expected) begin
      passes++;
    end else begin
      $error("FAIL %s: count=%0d expected=%0d", tag, count, expected);
    end
  endtask

  // Drive between edges; the prior result must hold until the next rising edge.
  task automatic step(input string tag, input logic rst, input logic [7:0] v,
                      input logic [3:0] prev, input logic [3:0] expected);
    @(negedge clk);
    reset = rst;
    in    = v;
    #1;
    check({tag, "_hold"}, prev);
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    in     = 8'h00;

    @(posedge clk);
    #1;
    check("reset", 4'd0);

    step("reset_priority", 1'b1, 8'hFF,        4'd0, 4'd0);
    step("zeros",          1'b0, 8'b00000000,  4'd0, 4'd0);
    step("ones",           1'b0, 8'b11111111,  4'd0, 4'd8);
    step("bit0",           1'b0, 8'b00000001,  4'd8, 4'd1);
    step("bit7",           1'b0, 8'b10000000,  4'd1, 4'd1);
    step("bit1",           1'b0, 8'b00000010,  4'd1, 4'd1);
    step("p_aa",           1'b0, 8'b10101010,  4'd1, 4'd4);
    step("p_55",           1'b0, 8'b01010101,  4'd4, 4'd4);
    step("p_3c",           1'b0, 8'b00111100,  4'd4, 4'd4);
    step("p_c3",           1'b0, 8'b11000011,  4'd4, 4'd4);
    step("p_96",           1'b0, 8'b10010110,  4'd4, 4'd4);
    step("p_66",           1'b0, 8'b01100110,  4'd4, 4'd4);
    step("p_18",           1'b0, 8'b00011000,  4'd4, 4'd2);
    step("p_41",           1'b0, 8'b01000001,  4'd2, 4'd2);
    step("p_24",           1'b0, 8'b00100100,  4'd2, 4'd2);
    step("p_7e",           1'b0, 8'b01111110,  4'd2, 4'd6);
    step("p_0f",           1'b0, 8'b00001111,  4'd6, 4'd4);
    step("p_f0",           1'b0, 8'b11110000,  4'd4, 4'd4);

    // Back-to-back words with distinct counts to expose skips or repeats.
    step("b2b_0",          1'b0, 8'b00000111,  4'd4, 4'd3);
    step("b2b_1",          1'b0, 8'b11111110,  4'd3, 4'd7);
    step("b2b_2",          1'b0, 8'b00100000,  4'd7, 4'd1);
    step("b2b_3",          1'b0, 8'b11011011,  4'd1, 4'd6);
    step("b2b_4",          1'b0, 8'b00000000,  4'd6, 4'd0);
    step("b2b_5",          1'b0, 8'b01011111,  4'd0, 4'd6);
    step("b2b_6",          1'b0, 8'b10001000,  4'd6, 4'd2);
    step("b2b_7",          1'b0, 8'b11111111,  4'd2, 4'd8);

    // Reset mid-stream with the input held.
    step("mid_load",       1'b0, 8'b01100110,  4'd8, 4'd4);
    step("mid_reset",      1'b1, 8'b01100110,  4'd4, 4'd0);
    step("mid_resume",     1'b0, 8'b01100110,  4'd0, 4'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
